// File: rtl/seq_divider_pkg.sv
// Shared core package for the sequential divider.
// Holds the divider FSM state encoding.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_e;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division step: trial subtract of the divisor
// from the shifted partial remainder, restore on borrow.
module div_step #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] rem,
    input  logic            dvd_bit,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] rem_next,
    output logic            q_bit
);

    logic [SIZE+1:0] diff;
    logic            unused_diff_msb;

    // Top bit is the borrow out of the SIZE+1-bit trial subtraction.
    assign diff            = {1'b0, rem, dvd_bit} - {2'b00, divisor};
    assign q_bit           = ~diff[SIZE+1];
    assign unused_diff_msb = diff[SIZE];
    assign rem_next        = q_bit ? diff[SIZE-1:0]
                                   : {rem[SIZE-2:0], dvd_bit};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, sign fix-up in a final cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic            flush_i,
    input  logic [SIZE-1:0] dividend_i,
    input  logic [SIZE-1:0] divisor_i,
    output logic [SIZE-1:0] quotient_o,
    output logic [SIZE-1:0] remainder_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            valid_o
);

    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
    localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

    div_state_e state_q, state_d;

    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] quo_q;
    logic [SIZE-1:0] rem_q;
    logic [SIZE-1:0] dsr_q;
    logic            sign_q_q;
    logic            sign_r_q;
    logic            special_q;

    logic            accept;
    logic            step;
    logic            fin;
    logic            dvd_neg;
    logic            dsr_neg;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [SIZE-1:0] dvd_mag;
    logic [SIZE-1:0] dsr_mag;
    logic [SIZE-1:0] rem_next;
    logic            q_bit;
    logic [SIZE-1:0] q_fix;
    logic [SIZE-1:0] r_fix;

    assign dvd_neg  = signed_i & dividend_i[SIZE-1];
    assign dsr_neg  = signed_i & divisor_i[SIZE-1];
    assign dvd_mag  = dvd_neg ? -dividend_i : dividend_i;
    assign dsr_mag  = dsr_neg ? -divisor_i : divisor_i;
    assign div_zero = (divisor_i == '0);
    assign ovf      = signed_i && (dividend_i == MIN_NEG)
                      && (divisor_i == '1);
    assign special  = div_zero | ovf;

    div_step #(
        .SIZE(SIZE)
    ) u_step (
        .rem     (rem_q),
        .dvd_bit (quo_q[SIZE-1]),
        .divisor (dsr_q),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    // Special results are stored final; only normal ones get signs applied.
    assign q_fix = (!special_q && sign_q_q) ? -quo_q : quo_q;
    assign r_fix = (!special_q && sign_r_q) ? -rem_q : rem_q;

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        accept  = 1'b1;
                        state_d = special ? FIX : CALC;
                    end
                end
                CALC: begin
                    step = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            special_q   <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            done_o      <= 1'b0;
            valid_o     <= 1'b0;
        end else if (flush_i) begin
            done_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            done_o <= fin;
            if (accept) begin
                valid_o   <= 1'b0;
                cnt_q     <= '0;
                dsr_q     <= dsr_mag;
                sign_q_q  <= dvd_neg ^ dsr_neg;
                sign_r_q  <= dvd_neg;
                special_q <= special;
                unique case (1'b1)
                    ovf: begin
                        quo_q <= dividend_i;
                        rem_q <= '0;
                    end
                    div_zero: begin
                        quo_q <= '1;
                        rem_q <= dividend_i;
                    end
                    default: begin
                        quo_q <= dvd_mag;
                        rem_q <= '0;
                    end
                endcase
            end
            // quo_q doubles as the dividend shift register.
            if (step) begin
                quo_q <= {quo_q[SIZE-2:0], q_bit};
                rem_q <= rem_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if (fin) begin
                quotient_o  <= q_fix;
                remainder_o <= r_fix;
                valid_o     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an
// arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        valid;

    int checks = 0;
    int failures = 0;

    seq_divider #(
        .SIZE(32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .signed_i   (sgn),
        .flush_i    (flush),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .quotient_o (quotient),
        .remainder_o(remainder),
        .busy_o     (busy),
        .done_o     (done),
        .valid_o    (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic s);
        return (b == 0) || (s && a == 32'h8000_0000 && b == 32'hffff_ffff);
    endfunction

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = 32'hffff_ffff;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
            q = a;
            r = 32'h0;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Caller sits at a negedge; returns at the negedge after the start edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a,
                                input logic [31:0] b, input logic s,
                                input int lat);
        logic [31:0] eq;
        logic [31:0] er;
        model(a, b, s, eq, er);
        check({tag, "_lat"}, 64'(lat), is_special(a, b, s) ? 64'd1 : 64'd33);
        check({tag, "_quo"}, 64'(quotient), 64'(eq));
        check({tag, "_rem"}, 64'(remainder), 64'(er));
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
        int lat;
        logic [31:0] q0;
        launch(a, b, s);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        check_result(tag, a, b, s, lat);
        q0 = quotient;
        dividend = $urandom;
        divisor  = $urandom;
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(quotient), 64'(q0));
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int mode;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        repeat (2) @(negedge clk);
        check("rst_quo", 64'(quotient), 64'd0);
        check("rst_rem", 64'(remainder), 64'd0);
        check("rst_flags", {61'd0, busy, done, valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("u100_7", 32'd100, 32'd7, 1'b0);
        run_op("s_m7_2", 32'hffff_fff9, 32'd2, 1'b1);
        run_op("s_dz", 32'h1234_5678, 32'd0, 1'b1);
        run_op("u_dz", 32'h1234_5678, 32'd0, 1'b0);
        run_op("s_ovf", 32'h8000_0000, 32'hffff_ffff, 1'b1);
        run_op("u_ovf", 32'h8000_0000, 32'hffff_ffff, 1'b0);

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("idle_flush_valid", 64'(valid), 64'd0);
        check("idle_flush_busy", 64'(busy), 64'd0);

        launch(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_valid", 64'(valid), 64'd0);
        count_done(40, cnt);
        check("flush_no_done", 64'(cnt), 64'd0);
        run_op("after_flush", 32'd9, 32'd3, 1'b0);

        launch(32'hdead_beef, 32'd17, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_quo", 64'(quotient), 64'd0);
        check("arst_rem", 64'(remainder), 64'd0);
        check("arst_flags", {61'd0, busy, done, valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, cnt);
        check("arst_no_done", 64'(cnt), 64'd0);

        launch(32'd500, 32'd9, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check_result("busy_start", 32'd500, 32'd9, 1'b0, lat + 6);

        launch(32'hffff_ff00, 32'd5, 1'b1);
        wait_done(lat);
        check_result("b2b_a", 32'hffff_ff00, 32'd5, 1'b1, lat);
        launch(32'd12345, 32'hffff_fffd, 1'b1);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_valid", 64'(valid), 64'd0);
        check("b2b_done", 64'(done), 64'd0);
        wait_done(lat);
        check_result("b2b_b", 32'd12345, 32'hffff_fffd, 1'b1, lat);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 7);
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case (mode)
                0: b = 32'd0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hffff_ffff;
                    s = 1'b1;
                end
                2: b = 32'($urandom_range(1, 20));
                3: b = 32'hffff_ffff - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op("rand", a, b, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter SIZE, default 32, operand width in bits (even, >=4).
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: request a division; sampled only while idle.
REQ-005 SHALL have port signed_i, input, 1 bit: 1 = two's-complement operands (DIV/REM); 0 = unsigned (DIVU/REMU); sampled with start_i.
REQ-006 SHALL have port flush_i, input, 1 bit: abort any operation in progress.
REQ-007 SHALL have port dividend_i, input, SIZE bits: dividend.
REQ-008 SHALL have port divisor_i, input, SIZE bits: divisor.
REQ-009 SHALL have port quotient_o, output, SIZE bits: quotient.
REQ-010 SHALL have port remainder_o, output, SIZE bits: remainder.
REQ-011 SHALL have port busy_o, output, 1 bit: calculation in progress.
REQ-012 SHALL have port done_o, output, 1 bit: completion pulse, high for exactly one cycle.
REQ-013 SHALL have port valid_o, output, 1 bit: outputs hold a valid result; cleared by the next accepted start or a flush.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX; reset state IDLE.
REQ-015 In IDLE with start_i=1, the block SHALL latch operands and signed_i, assert busy_o, clear valid_o, and take one of the next two actions.
REQ-016 If the start is special (REQ-020/021), the next state SHALL be FIX; otherwise the next state SHALL be CALC with the step counter set to 0.
REQ-017 In signed mode, the block SHALL divide operand magnitudes and record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
REQ-018 CALC SHALL perform one restoring step per cycle, MSB first, for exactly SIZE cycles.
REQ-019 Each CALC step SHALL be: partial remainder (SIZE+1 bits) = {rem, next dividend bit} minus divisor; if non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
REQ-020 Divide-by-zero SHALL produce quotient all-ones and remainder = dividend, in both modes; no trap.
REQ-021 Signed overflow (dividend = most-negative value, divisor = -1) SHALL produce quotient = dividend and remainder = 0.
REQ-022 FIX SHALL negate the quotient if sign_q and negate the remainder if sign_r (signed, non-special only), drive the outputs, then return to IDLE.
REQ-023 On exit from FIX, the block SHALL assert done_o and valid_o and deassert busy_o on the same edge.
REQ-024 Latency from the start edge to done_o high SHALL be SIZE+1 cycles for normal operations and 1 cycle for special cases.
REQ-025 start_i while busy_o=1 SHALL be ignored.
REQ-026 start_i in the same cycle as done_o=1 SHALL be accepted, because the FSM is IDLE in that cycle.
REQ-027 flush_i SHALL have priority over start_i: go to IDLE, clear busy_o, done_o and valid_o, and leave quotient_o/remainder_o don't-care.
REQ-028 flush_i while IDLE SHALL clear valid_o and have no other effect.
REQ-029 quotient_o/remainder_o SHALL remain stable while valid_o=1.

Reset
REQ-030 Asserting rst_ni low SHALL immediately force IDLE and quotient_o=0, remainder_o=0, busy_o=0, done_o=0, valid_o=0, counter=0, with internal registers cleared, regardless of clk_i.
REQ-031 Reset asserted mid-CALC SHALL discard the operation; no done_o pulse SHALL follow deassertion.

Structure
REQ-032 The FSM state enum (div_state_e) SHALL be defined in the shared core package, not locally.
REQ-033 The counter width $clog2(SIZE)+1 SHALL be derived from SIZE in the module.
REQ-034 The restoring step SHALL be a single combinational sub-module, div_step, with inputs rem, dividend bit and divisor, and outputs next rem and quotient bit.
REQ-035 There SHALL be no multi-cycle or false paths; a single SIZE+1-bit subtractor SHALL be used per cycle.

Verification
REQ-036 Unsigned 100 / 7 -> done_o at cycle 33, quotient 14, remainder 2.
REQ-037 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-038 0x12345678 / 0, signed and unsigned -> done_o after 1 cycle, quotient 0xFFFFFFFF, remainder 0x12345678.
REQ-039 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, latency 1.
REQ-040 start_i, then flush_i at cycle 10, then a new start with 9/3 -> no done_o for the first operation; second gives quotient 3, remainder 0.
REQ-041 rst_ni pulsed low mid-CALC; start_i pulsed during busy_o; back-to-back start on the done_o cycle -> all outputs 0 immediately, busy-time start ignored, back-to-back start accepted.
